// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: arbitrates three reservation stations into a fixed-latency multiplier
// and returns results in issue order over the CDB. Define MUL_RR_ARB_EN for round-robin arbitration.
module mul_issue_ctrl #(
   parameter int unsigned LAT        = 6,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TAG_W      = 4
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic [2:0]         rs_req,
   input  logic [95:0]        rs_op1,
   input  logic [95:0]        rs_op2,
   input  logic [3*TAG_W-1:0] rs_tag,
   output logic [2:0]         rs_grant,
   output logic               mul_en,
   output logic [31:0]        mul_a,
   output logic [31:0]        mul_b,
   input  logic [31:0]        mul_result,
   output logic               cdb_valid,
   output logic [TAG_W-1:0]   cdb_tag,
   output logic [31:0]        cdb_data,
   input  logic               cdb_ack,
   output logic               busy
);

   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PTR_MAX_I = FIFO_DEPTH - 1;
   localparam logic [CNT_W:0]   CREDITS = FIFO_DEPTH[CNT_W:0];
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_MAX_I[PTR_W-1:0];

   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LAT-1:0]   sr_valid_q;
   logic [TAG_W-1:0] sr_tag_q    [LAT];
   logic [TAG_W-1:0] fifo_tag_q  [FIFO_DEPTH];
   logic [31:0]      fifo_data_q [FIFO_DEPTH];

   logic             credit_ok;
   logic             fifo_wr;
   logic             fifo_pop;
   logic [1:0]       gnt_idx;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic [TAG_W-1:0] sel_tag;

   // ---------------------------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------------------------
`ifdef MUL_RR_ARB_EN
   logic [1:0] rr_ptr_q;  // slot where the next search starts

   function automatic logic [1:0] slot_add(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, off};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_idx = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (rs_req[slot_add(rr_ptr_q, 2'(k))]) begin
            gnt_idx = slot_add(rr_ptr_q, 2'(k));
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rr_ptr_q <= 2'd0;
      end else if (mul_en) begin
         rr_ptr_q <= slot_add(gnt_idx, 2'd1);
      end
   end
`else
   always_comb begin
      if (rs_req[0]) begin
         gnt_idx = 2'd0;
      end else if (rs_req[1]) begin
         gnt_idx = 2'd1;
      end else begin
         gnt_idx = 2'd2;
      end
   end
`endif

   always_comb begin
      case (gnt_idx)
         2'd1: begin
            sel_a   = rs_op1[63:32];
            sel_b   = rs_op2[63:32];
            sel_tag = rs_tag[2*TAG_W-1:TAG_W];
         end
         2'd2: begin
            sel_a   = rs_op1[95:64];
            sel_b   = rs_op2[95:64];
            sel_tag = rs_tag[3*TAG_W-1:2*TAG_W];
         end
         default: begin
            sel_a   = rs_op1[31:0];
            sel_b   = rs_op2[31:0];
            sel_tag = rs_tag[TAG_W-1:0];
         end
      endcase
   end

   // Credits come only from registered counts, so a pop frees a slot for the next cycle.
   assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CREDITS;
   assign mul_en    = (|rs_req) & credit_ok;
   assign rs_grant  = mul_en ? (3'b001 << gnt_idx) : 3'b000;
   assign mul_a     = mul_en ? sel_a : 32'd0;
   assign mul_b     = mul_en ? sel_b : 32'd0;

   // ---------------------------------------------------------------------------------------------
   // Tag shift register tracking the multiplier pipeline
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         sr_valid_q <= '0;
      end else begin
         sr_valid_q[0] <= mul_en;
         for (int i = 1; i < LAT; i++) begin
            sr_valid_q[i] <= sr_valid_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      sr_tag_q[0] <= sel_tag;
      for (int i = 1; i < LAT; i++) begin
         sr_tag_q[i] <= sr_tag_q[i-1];
      end
   end

   assign fifo_wr  = sr_valid_q[LAT-1];
   assign fifo_pop = cdb_valid & cdb_ack;

   // ---------------------------------------------------------------------------------------------
   // Result FIFO and counters
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      inflight_d = inflight_q;
      case ({mul_en, fifo_wr})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      case ({fifo_wr, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         if (fifo_wr) begin
            wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_tag_q[wr_ptr_q]  <= sr_tag_q[LAT-1];
         fifo_data_q[wr_ptr_q] <= mul_result;
      end
   end

   // Head is gated so the CDB outputs read zero whenever nothing is offered, including in reset.
   assign cdb_valid = (fifo_cnt_q != '0);
   assign cdb_tag   = cdb_valid ? fifo_tag_q[rd_ptr_q]  : '0;
   assign cdb_data  = cdb_valid ? fifo_data_q[rd_ptr_q] : 32'd0;
   assign busy      = (inflight_q != '0) | (fifo_cnt_q != '0);

   // ---------------------------------------------------------------------------------------------
   // Checks: the pipeline cannot stall, so a write into a full buffer would lose a result.
   // ---------------------------------------------------------------------------------------------
   a_no_full_write: assert property (@(posedge clk) disable iff (!nRST)
      fifo_wr |-> ({1'b0, fifo_cnt_q} < CREDITS));
   a_grant_onehot: assert property (@(posedge clk) disable iff (!nRST) $onehot0(rs_grant));
   a_no_inflight_underflow: assert property (@(posedge clk) disable iff (!nRST)
      fifo_wr |-> (inflight_q != '0));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: table-driven single-op/mux vectors plus hand sequences for credits,
// arbitration, ordering, simultaneous write/pop and mid-operation reset.
module tb_mul_issue_ctrl;

   localparam int unsigned LAT        = 6;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned TAG_W      = 4;

   logic               clk = 1'b0;
   logic               nRST;
   logic [2:0]         rs_req;
   logic [95:0]        rs_op1;
   logic [95:0]        rs_op2;
   logic [3*TAG_W-1:0] rs_tag;
   logic [2:0]         rs_grant;
   logic               mul_en;
   logic [31:0]        mul_a;
   logic [31:0]        mul_b;
   logic [31:0]        mul_result;
   logic               cdb_valid;
   logic [TAG_W-1:0]   cdb_tag;
   logic [31:0]        cdb_data;
   logic               cdb_ack;
   logic               busy;

   int checks   = 0;
   int failures = 0;

   mul_issue_ctrl #(
      .LAT        (LAT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TAG_W      (TAG_W)
   ) dut (
      .clk        (clk),
      .nRST       (nRST),
      .rs_req     (rs_req),
      .rs_op1     (rs_op1),
      .rs_op2     (rs_op2),
      .rs_tag     (rs_tag),
      .rs_grant   (rs_grant),
      .mul_en     (mul_en),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .cdb_ack    (cdb_ack),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Multiplier model: LAT-stage, non-stalling, truncated product.
   logic [31:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= mul_en ? mul_a * mul_b : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_result = mpipe[LAT-1];

   typedef struct {
      logic [2:0]  req;
      logic        ack;
      logic [2:0]  gnt;
      logic        en;
      logic [31:0] a;
      logic [31:0] b;
      logic        cv;
      logic [3:0]  ctag;
      logic [31:0] cdata;
      logic        bsy;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(input logic [2:0] req, input logic ack, input logic [2:0] gnt,
                               input logic en, input logic [31:0] a, input logic [31:0] b,
                               input logic cv, input logic [3:0] ctag, input logic [31:0] cdata,
                               input logic bsy);
      vec_t v;
      v.req = req; v.ack = ack; v.gnt = gnt; v.en = en; v.a = a; v.b = b;
      v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.bsy = bsy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycles start 1 time unit after the rising edge; outputs are sampled mid-cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nRST    = 1'b0;
      rs_req  = 3'b000;
      cdb_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
      chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
      chk("rst_cdb_data", cdb_data, 32'd0);
      @(posedge clk);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int ngrant;
      int ncv;
      logic [2:0] arb_exp [4];

      rs_op1 = {32'd11, 32'd7, 32'd13};
      rs_op2 = {32'd21, 32'd6, 32'd23};
      rs_tag = {4'd3, 4'd5, 4'd7};

      // Single op on RS1 (7*6, tag 5), then mux checks on the other slots.
      tbl[0] = mk(3'b010, 1'b1, 3'b010, 1'b1, 32'd7, 32'd6, 1'b0, 4'd0, 32'd0, 1'b0);
      for (int i = 1; i <= 6; i++)
         tbl[i] = mk(3'b000, 1'b1, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
      tbl[7]  = mk(3'b000, 1'b1, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1, 4'd5, 32'd42, 1'b1);
      tbl[8]  = mk(3'b000, 1'b1, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      tbl[9]  = mk(3'b100, 1'b1, 3'b100, 1'b1, 32'd11, 32'd21, 1'b0, 4'd0, 32'd0, 1'b0);
      tbl[10] = mk(3'b001, 1'b1, 3'b001, 1'b1, 32'd13, 32'd23, 1'b0, 4'd0, 32'd0, 1'b1);
`ifdef MUL_RR_ARB_EN
      tbl[11] = mk(3'b011, 1'b1, 3'b010, 1'b1, 32'd7, 32'd6, 1'b0, 4'd0, 32'd0, 1'b1);
      arb_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
      tbl[11] = mk(3'b011, 1'b1, 3'b001, 1'b1, 32'd13, 32'd23, 1'b0, 4'd0, 32'd0, 1'b1);
      arb_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif

      do_reset();
      for (int i = 0; i < 12; i++) begin
         rs_req  = tbl[i].req;
         cdb_ack = tbl[i].ack;
         #4;
         chk($sformatf("vec%0d_grant", i), 32'(rs_grant), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d_mul_en", i), 32'(mul_en), 32'(tbl[i].en));
         chk($sformatf("vec%0d_mul_a", i), mul_a, tbl[i].a);
         chk($sformatf("vec%0d_mul_b", i), mul_b, tbl[i].b);
         chk($sformatf("vec%0d_cdb_valid", i), 32'(cdb_valid), 32'(tbl[i].cv));
         chk($sformatf("vec%0d_cdb_tag", i), 32'(cdb_tag), 32'(tbl[i].ctag));
         chk($sformatf("vec%0d_cdb_data", i), cdb_data, tbl[i].cdata);
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
         next_cycle();
      end

      // Credit backpressure: four grants, then none until a pop frees a credit next cycle.
      do_reset();
      rs_op1  = {32'd5, 32'd4, 32'd2};
      rs_op2  = {32'd5, 32'd4, 32'd3};
      rs_req  = 3'b111;
      cdb_ack = 1'b0;
      ngrant  = 0;
      for (int c = 0; c < 20; c++) begin
         #4;
         if (rs_grant != 3'b000) ngrant++;
         next_cycle();
      end
      chk("bp_grants_before_ack", 32'(ngrant), 32'd4);
      cdb_ack = 1'b1;
      #4;
      chk("bp_cdb_valid_full", 32'(cdb_valid), 32'd1);
      chk("bp_head_data", cdb_data, 32'd6);
      chk("bp_no_same_cycle_credit", 32'(rs_grant), 32'd0);
      next_cycle();
      cdb_ack = 1'b0;
      #4;
      chk("bp_grant_after_ack", 32'(mul_en), 32'd1);
      next_cycle();
      ngrant = 0;
      for (int c = 0; c < 10; c++) begin
         #4;
         if (rs_grant != 3'b000) ngrant++;
         next_cycle();
      end
      chk("bp_no_extra_grant", 32'(ngrant), 32'd0);

      // Arbitration order with all requesting and the CDB draining.
      do_reset();
      rs_req  = 3'b111;
      cdb_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #4;
         chk($sformatf("arb_grant_%0d", k), 32'(rs_grant), 32'(arb_exp[k]));
         next_cycle();
      end

      // Order and truncation.
      do_reset();
      cdb_ack      = 1'b1;
      rs_req       = 3'b001;
      rs_op1[31:0] = 32'hFFFF_FFFF;
      rs_op2[31:0] = 32'd2;
      rs_tag[3:0]  = 4'd1;
      next_cycle();
      rs_op1[31:0] = 32'h0001_0000;
      rs_op2[31:0] = 32'h0001_0000;
      rs_tag[3:0]  = 4'd2;
      #4;
      chk("ord_second_issue", 32'(mul_en), 32'd1);
      next_cycle();
      rs_req = 3'b000;
      repeat (5) next_cycle();
      #4;
      chk("ord_first_valid", 32'(cdb_valid), 32'd1);
      chk("ord_first_tag", 32'(cdb_tag), 32'd1);
      chk("ord_first_data", cdb_data, 32'hFFFF_FFFE);
      next_cycle();
      #4;
      chk("ord_second_valid", 32'(cdb_valid), 32'd1);
      chk("ord_second_tag", 32'(cdb_tag), 32'd2);
      chk("ord_second_data", cdb_data, 32'h0000_0000);
      next_cycle();
      #4;
      chk("ord_drained", 32'(cdb_valid), 32'd0);
      next_cycle();

      // Write coinciding with a pop at two entries.
      do_reset();
      cdb_ack      = 1'b0;
      rs_req       = 3'b001;
      rs_op1[31:0] = 32'd3;   rs_op2[31:0] = 32'd5;   rs_tag[3:0] = 4'd1;
      next_cycle();
      rs_op1[31:0] = 32'd4;   rs_op2[31:0] = 32'd5;   rs_tag[3:0] = 4'd2;
      next_cycle();
      rs_op1[31:0] = 32'd100; rs_op2[31:0] = 32'd100; rs_tag[3:0] = 4'd3;
      next_cycle();
      rs_req = 3'b000;
      repeat (5) next_cycle();
      cdb_ack = 1'b1;
      #4;
      chk("sim_cnt_before", 32'(dut.fifo_cnt_q), 32'd2);
      chk("sim_head1_tag", 32'(cdb_tag), 32'd1);
      chk("sim_head1_data", cdb_data, 32'd15);
      next_cycle();
      cdb_ack = 1'b0;
      #4;
      chk("sim_cnt_after", 32'(dut.fifo_cnt_q), 32'd2);
      chk("sim_head2_tag", 32'(cdb_tag), 32'd2);
      chk("sim_head2_data", cdb_data, 32'd20);
      next_cycle();
      cdb_ack = 1'b1;
      #4;
      chk("sim_head2_held", 32'(cdb_tag), 32'd2);
      next_cycle();
      #4;
      chk("sim_head3_tag", 32'(cdb_tag), 32'd3);
      chk("sim_head3_data", cdb_data, 32'd10000);
      next_cycle();
      #4;
      chk("sim_empty", 32'(cdb_valid), 32'd0);
      chk("sim_idle", 32'(busy), 32'd0);
      next_cycle();

      // Reset mid-operation discards in-flight results.
      do_reset();
      cdb_ack      = 1'b1;
      rs_req       = 3'b001;
      rs_op1[31:0] = 32'd2; rs_op2[31:0] = 32'd2; rs_tag[3:0] = 4'd4;
      next_cycle();
      rs_tag[3:0] = 4'd6;
      next_cycle();
      rs_req = 3'b000;
      next_cycle();
      nRST = 1'b0;
      #2;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cdb_valid", 32'(cdb_valid), 32'd0);
      #2;
      nRST = 1'b1;
      next_cycle();
      ncv = 0;
      for (int c = 0; c < 10; c++) begin
         #4;
         if (cdb_valid) ncv++;
         next_cycle();
      end
      chk("mid_rst_no_stale", 32'(ncv), 32'd0);
      rs_req        = 3'b010;
      rs_op1[63:32] = 32'd3;
      rs_op2[63:32] = 32'd3;
      rs_tag[7:4]   = 4'd9;
      #4;
      chk("mid_rst_reissue", 32'(rs_grant), 32'(3'b010));
      next_cycle();
      rs_req = 3'b000;
      repeat (5) next_cycle();
      #4;
      chk("mid_rst_not_early", 32'(cdb_valid), 32'd0);
      next_cycle();
      #4;
      chk("mid_rst_valid", 32'(cdb_valid), 32'd1);
      chk("mid_rst_tag", 32'(cdb_tag), 32'd9);
      chk("mid_rst_data", cdb_data, 32'd9);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter LAT, default 6: multiplier pipeline latency in cycles from issue to valid result; fixed to the multiplier datapath depth.
REQ-002 Parameter FIFO_DEPTH, default 4: result-buffer entries, which is also the maximum outstanding operations.
REQ-003 Parameter TAG_W, default 4: reservation-station tag width.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 nRST  in  1: reset, asynchronous, active-low.
REQ-006 rs_req  in  3: per-reservation-station request, bit i set when RS i holds a ready multiply.
REQ-007 rs_op1, rs_op2  in  96 each: operands, slot i at bits [32i+31:32i].
REQ-008 rs_tag  in  3*TAG_W: destination tag, slot i at bits [TAG_W*i+TAG_W-1:TAG_W*i].
REQ-009 rs_grant  out  3: one-hot grant; the granted RS deasserts its request next cycle.
REQ-010 mul_en  out  1: issue strobe to the multiplier stage-1 enable.
REQ-011 mul_a, mul_b  out  32 each: operands of the granted slot; all-zero when mul_en is 0.
REQ-012 mul_result  in  32: multiplier output, 32-bit truncated product.
REQ-013 cdb_valid  out  1: result offered to the common data bus.
REQ-014 cdb_tag  out  TAG_W, cdb_data  out  32: offered tag and result.
REQ-015 cdb_ack  in  1: CDB accepted the offered result this cycle.
REQ-016 busy  out  1: set if any operation is in flight or buffered.

Function
REQ-017 The issue condition SHALL be |rs_req and (inflight_cnt + fifo_cnt) < FIFO_DEPTH, both counts taken from registered values.
REQ-018 rs_grant and mul_en SHALL be combinational in the issue cycle; at most one grant per cycle; no grant when the issue condition is false.
REQ-019 The tag of an issue in cycle t SHALL enter a LAT-deep valid/tag shift register at the end of cycle t.
REQ-020 mul_result SHALL be written to the FIFO with the shifted tag at the end of cycle t+LAT; cdb_valid is asserted no earlier than cycle t+LAT+1.
REQ-021 The multiplier pipeline cannot stall; the credit rule guarantees a FIFO slot at every write, and a write to a full FIFO is a design error that the assertions check.
REQ-022 The FIFO head SHALL drive cdb_tag/cdb_data while cdb_valid=1; these outputs are held stable until cdb_ack.
REQ-023 cdb_valid & cdb_ack SHALL pop the head at the end of the cycle; cdb_ack with cdb_valid=0 is ignored.
REQ-024 A simultaneous FIFO write and pop SHALL leave fifo_cnt unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 A credit freed by a pop SHALL be usable from the next cycle, not the same cycle.
REQ-026 inflight_cnt SHALL be incremented on issue and decremented on FIFO write; a simultaneous issue and write leaves it unchanged.
REQ-027 Results SHALL leave in issue order.
REQ-028 busy = (inflight_cnt != 0) | (fifo_cnt != 0).

Reset
REQ-029 nRST low SHALL immediately clear: shift-register valids, counters, FIFO pointers, arbiter pointer (pointing at RS0), cdb_valid, cdb_tag, cdb_data, and busy.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and buffered results; no cdb_valid may appear for them after release.
REQ-031 The first issue SHALL be possible in the first cycle after nRST rises.

Configuration
REQ-032 The macro is MUL_RR_ARB_EN.
REQ-033 With MUL_RR_ARB_EN defined, arbitration SHALL be round-robin: the search starts at the slot after the last granted slot, and the pointer updates only on issue.
REQ-034 With MUL_RR_ARB_EN undefined, arbitration SHALL be fixed priority RS0 > RS1 > RS2, with no pointer state.

Verification
REQ-035 Single op: RS1 issues 7*6 with tag 5 in cycle 0 and cdb_ack is held 1 -> cdb_valid in cycle 7 with tag 5 and data 42, and busy returns to 0 in cycle 8.
REQ-036 Credit backpressure: all RS requesting continuously with cdb_ack=0 -> exactly 4 grants, then no grant until an ack; after one ack, exactly one further grant the next cycle.
REQ-037 Round-robin (MUL_RR_ARB_EN): rs_req=3'b111 held and the FIFO drained each cycle -> grant sequence RS0, RS1, RS2, RS0. Without the macro: RS0 every cycle.
REQ-038 Order and width: back-to-back issues 0xFFFFFFFF*2 (tag 1) then 0x10000*0x10000 (tag 2) -> CDB shows tag 1 with data 0xFFFFFFFE, then tag 2 with data 0x00000000.
REQ-039 Simultaneous events: FIFO write coincides with an ack while fifo_cnt=2 -> fifo_cnt stays 2, and no entry is lost or duplicated.
REQ-040 Reset mid-operation: nRST pulsed low in cycle 3 after two issues -> no cdb_valid for 10 cycles; then a new op 3*3 with tag 9 yields 9 with tag 9 at issue+7.
